isa_io_arbiter: RTL and testbench

//   Shares the single ISA I/O cycle engine (address/data_out/data_dir/strobe) between two

---
 rtl/isa_io_arbiter_if.sv | 30 +++
 rtl/isa_io_arbiter.sv | 164 ++++++++++++++++
 tb/tb_isa_io_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_io_arbiter_if.sv
// isa_io_arbiter_if: bundle of the requester handshake and the ISA cycle-engine pins.
//   Requester side : req_valid/req_write/req_addr/req_wdata in, req_done/req_err/rdata out.
//   Bus side       : address/data_out/data_dir/bus_strobe out, bus_ack/data_in in.
// The slave modport is the arbiter's view. The master modport is the environment's view,
// which covers both the requesters and the pin driver.
interface isa_io_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [31:0] req_addr;   // {addr1, addr0}
  logic [31:0] req_wdata;  // {wdata1, wdata0}
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [15:0] rdata;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        data_dir;
  logic        bus_strobe;
  logic        bus_ack;
  logic [15:0] data_in;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, bus_ack, data_in,
    input  req_done, req_err, rdata, address, data_out, data_dir, bus_strobe
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, bus_ack, data_in,
    output req_done, req_err, rdata, address, data_out, data_dir, bus_strobe
  );
endinterface

// File: rtl/isa_io_arbiter.sv
// isa_io_arbiter: round-robin share of the single ISA I/O cycle engine between the DSP reset
// sequencer (req 0) and the DSP command/data path (req 1). Each grant runs
// SETUP -> STROBE -> RELEASE, then TURNAROUND idle cycles, then IDLE re-arbitrates.
// Ports:
//   sys_clock  - system clock, rising edge
//   set_safe   - asynchronous active-high reset; drops the strobe at once and issues no done
//   io         - isa_io_arbiter_if.slave: requester handshake plus ISA cycle-engine pins
// All outputs are registered. The address/data/dir output registers double as the latched
// copy of the granted request, so later changes on the request inputs have no effect.
module isa_io_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8,
  parameter int unsigned TURNAROUND     = 2
) (
  input logic             sys_clock,
  input logic             set_safe,
  isa_io_arbiter_if.slave io
);

  localparam logic [TO_W-1:0] TimeoutMax = TO_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]      TurnMax    = 3'(TURNAROUND);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StRelease, StTurn} state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]      turn_cnt_q, turn_cnt_d;
  logic [15:0]     address_q, address_d;
  logic [15:0]     data_out_q, data_out_d;
  logic            data_dir_q, data_dir_d;
  logic            strobe_q, strobe_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic [15:0]     rdata_q, rdata_d;

  logic            gnt;
  logic [15:0]     sel_addr;
  logic [15:0]     sel_wdata;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    to_cnt_d     = to_cnt_q;
    turn_cnt_d   = turn_cnt_q;
    address_d    = address_q;
    data_out_d   = data_out_q;
    data_dir_d   = data_dir_q;
    strobe_d     = 1'b0;
    done_d       = 2'b00;
    err_d        = 2'b00;
    rdata_d      = rdata_q;
    gnt          = 1'b0;
    sel_addr     = 16'h0000;
    sel_wdata    = 16'h0000;

    unique case (state_q)
      StIdle: begin
        if (io.req_valid != 2'b00) begin
          // With both requesting, the one not served last wins.
          if (io.req_valid == 2'b11) begin
            gnt = ~last_grant_q;
          end else begin
            gnt = io.req_valid[1];
          end
          sel_addr     = gnt ? io.req_addr[31:16] : io.req_addr[15:0];
          sel_wdata    = gnt ? io.req_wdata[31:16] : io.req_wdata[15:0];
          last_grant_d = gnt;
          address_d    = sel_addr;
          data_dir_d   = io.req_write[gnt];
          data_out_d   = io.req_write[gnt] ? sel_wdata : 16'h0000;
          state_d      = StSetup;
        end
      end

      StSetup: begin
        strobe_d = 1'b1;
        to_cnt_d = TO_W'(1);
        state_d  = StStrobe;
      end

      StStrobe: begin
        // Ack is checked first so an ack on the final allowed cycle is not an error.
        if (io.bus_ack) begin
          state_d                = StRelease;
          done_d[last_grant_q]   = 1'b1;
          if (!data_dir_q) begin
            rdata_d = io.data_in;
          end
        end else if (to_cnt_q == TimeoutMax) begin
          state_d                = StRelease;
          done_d[last_grant_q]   = 1'b1;
          err_d[last_grant_q]    = 1'b1;
          if (!data_dir_q) begin
            rdata_d = 16'hFFFF;
          end
        end else begin
          strobe_d = 1'b1;
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      StRelease: begin
        address_d  = 16'h0000;
        data_out_d = 16'h0000;
        data_dir_d = 1'b1;
        turn_cnt_d = 3'd1;
        state_d    = (TURNAROUND == 0) ? StIdle : StTurn;
      end

      StTurn: begin
        if (turn_cnt_q == TurnMax) begin
          state_d = StIdle;
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end
      end

      default: begin
        state_d    = StIdle;
        address_d  = 16'h0000;
        data_out_d = 16'h0000;
        data_dir_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clock or posedge set_safe) begin
    if (set_safe) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      to_cnt_q     <= '0;
      turn_cnt_q   <= 3'd0;
      address_q    <= 16'h0000;
      data_out_q   <= 16'h0000;
      data_dir_q   <= 1'b1;
      strobe_q     <= 1'b0;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      rdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      to_cnt_q     <= to_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      address_q    <= address_d;
      data_out_q   <= data_out_d;
      data_dir_q   <= data_dir_d;
      strobe_q     <= strobe_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign io.address    = address_q;
  assign io.data_out   = data_out_q;
  assign io.data_dir   = data_dir_q;
  assign io.bus_strobe = strobe_q;
  assign io.req_done   = done_q;
  assign io.req_err    = err_q;
  assign io.rdata      = rdata_q;

endmodule

// File: tb/tb_isa_io_arbiter.sv
// tb_isa_io_arbiter: directed stimulus with a scoreboard. Each issued request pushes its
// expected completion; the monitor pops and compares whenever req_done pulses.
module tb_isa_io_arbiter;

  localparam int TO   = 4;
  localparam int TURN = 2;

  logic clk = 1'b0;
  logic set_safe;

  isa_io_arbiter_if io ();

  isa_io_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .TO_W          (8),
    .TURNAROUND    (TURN)
  ) dut (
    .sys_clock(clk),
    .set_safe (set_safe),
    .io       (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  done;
    logic [1:0]  err;
    logic [15:0] addr;
    logic [15:0] data;
    logic        dir;
    logic        chk_rd;
    logic [15:0] rdata;
    int          strobes;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ack_at   = 0;   // strobe cycle on which the pin driver acks; 0 = never
  int   strobe_seen = 0;
  int   gap = 0;
  bit   gap_run = 1'b0;
  bit   gap_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pin driver: raise bus_ack during strobe cycle number ack_at.
  initial begin
    int sk;
    sk = 0;
    forever begin
      @(negedge clk);
      if (io.bus_strobe) begin
        sk++;
        io.bus_ack = (ack_at != 0) && (sk == ack_at);
      end else begin
        sk = 0;
        io.bus_ack = 1'b0;
      end
    end
  end

  // Monitor: strobe counting, scoreboard compare on req_done, idle gap after RELEASE.
  always @(negedge clk) begin
    exp_t e;
    if (set_safe) begin
      strobe_seen = 0;
      gap_run     = 1'b0;
    end else begin
      if (io.bus_strobe) strobe_seen++;
      if (io.req_done != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(io.req_done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("done",     32'(io.req_done), 32'(e.done));
          chk("err",      32'(io.req_err),  32'(e.err));
          chk("address",  32'(io.address),  32'(e.addr));
          chk("data_out", 32'(io.data_out), 32'(e.data));
          chk("data_dir", 32'(io.data_dir), 32'(e.dir));
          chk("strobes",  32'(strobe_seen), 32'(e.strobes));
          if (e.chk_rd) chk("rdata", 32'(io.rdata), 32'(e.rdata));
        end
        strobe_seen = 0;
        gap_run     = 1'b1;
        gap         = 0;
      end else if (gap_run) begin
        if (io.address != 16'h0000) begin
          // TURN cycles plus the IDLE arbitration cycle.
          if (gap_en) chk("turn_gap", 32'(gap), 32'(TURN + 1));
          gap_run = 1'b0;
        end else begin
          gap++;
        end
      end
    end
  end

  task automatic run_one(input int r, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input int ack, input logic [15:0] rd,
                         input bit perturb);
    exp_t e;
    bit   timed_out;
    bit   seen;
    @(negedge clk);
    ack_at     = ack;
    io.data_in = rd;
    io.req_addr[r*16 +: 16]  = a;
    io.req_wdata[r*16 +: 16] = d;
    io.req_write[r]          = wr;
    timed_out = (ack < 1) || (ack > TO);
    e.done    = (r == 0) ? 2'b01 : 2'b10;
    e.err     = timed_out ? e.done : 2'b00;
    e.addr    = a;
    e.data    = wr ? d : 16'h0000;
    e.dir     = wr;
    e.chk_rd  = !wr;
    e.rdata   = timed_out ? 16'hFFFF : rd;
    e.strobes = timed_out ? TO : ack;
    q.push_back(e);
    io.req_valid[r] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("setup_addr",   32'(io.address),    32'(a));
        chk("setup_strobe", 32'(io.bus_strobe), 32'd0);
        if (perturb) begin
          io.req_addr[r*16 +: 16]  = 16'hDEAD;
          io.req_wdata[r*16 +: 16] = 16'hDEAD;
          io.req_write[r]          = ~wr;
        end
      end
      if (i == 1) chk("strobe_on", 32'(io.bus_strobe), 32'd1);
      if (io.req_done[r]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_wait", 32'd0, 32'd1);
    io.req_valid[r] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int  dones;
    bit  seen;
    io.req_valid = 2'b00;
    io.req_write = 2'b00;
    io.req_addr  = 32'h0;
    io.req_wdata = 32'h0;
    io.bus_ack   = 1'b0;
    io.data_in   = 16'h0;
    set_safe     = 1'b1;
    #12;
    chk("rst_address", 32'(io.address),    32'h0);
    chk("rst_data_out", 32'(io.data_out),  32'h0);
    chk("rst_data_dir", 32'(io.data_dir),  32'h1);
    chk("rst_strobe",  32'(io.bus_strobe), 32'h0);
    chk("rst_done",    32'(io.req_done),   32'h0);
    chk("rst_err",     32'(io.req_err),    32'h0);
    chk("rst_rdata",   32'(io.rdata),      32'h0);
    @(negedge clk);
    set_safe = 1'b0;
    repeat (2) @(negedge clk);

    // Single write, ack on second strobe cycle.
    run_one(0, 1'b1, 16'h0206, 16'h0001, 2, 16'h0000, 1'b0);
    // Read with immediate ack.
    run_one(1, 1'b0, 16'h020A, 16'h0000, 1, 16'h00AA, 1'b0);
    // Timeout with no ack.
    run_one(0, 1'b0, 16'h0210, 16'h0000, 0, 16'h1111, 1'b0);
    // Ack on the last allowed strobe cycle wins over timeout.
    run_one(1, 1'b0, 16'h0214, 16'h0000, 4, 16'h1357, 1'b0);
    // Request inputs change after the grant; latched copy must be used.
    run_one(0, 1'b1, 16'h0220, 16'hBEEF, 3, 16'h0000, 1'b1);

    // Reset in the middle of STROBE.
    @(negedge clk);
    ack_at          = 0;
    io.req_addr[15:0] = 16'h0230;
    io.req_write[0] = 1'b0;
    io.req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io.bus_strobe) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("strobe_wait", 32'd0, 32'd1);
    @(negedge clk);
    #2 set_safe = 1'b1;
    #1;
    chk("async_strobe",  32'(io.bus_strobe), 32'h0);
    chk("async_address", 32'(io.address),    32'h0);
    chk("async_dir",     32'(io.data_dir),   32'h1);
    io.req_valid = 2'b00;
    @(negedge clk);
    set_safe = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (io.req_done != 2'b00) dones++;
    end
    chk("no_done_after_reset", 32'(dones), 32'd0);

    // Contention from reset: both valid continuously, grants alternate starting with req 0.
    set_safe = 1'b1;
    ack_at   = 1;
    io.data_in         = 16'h55AA;
    io.req_addr        = {16'h0310, 16'h0300};
    io.req_wdata       = {16'h0000, 16'h1234};
    io.req_write       = 2'b01;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.done    = (k % 2 == 0) ? 2'b01 : 2'b10;
      e.err     = 2'b00;
      e.addr    = (k % 2 == 0) ? 16'h0300 : 16'h0310;
      e.data    = (k % 2 == 0) ? 16'h1234 : 16'h0000;
      e.dir     = (k % 2 == 0);
      e.chk_rd  = (k % 2 == 1);
      e.rdata   = 16'h55AA;
      e.strobes = 1;
      q.push_back(e);
    end
    io.req_valid = 2'b11;
    @(negedge clk);
    set_safe = 1'b0;
    gap_en   = 1'b1;
    dones    = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (io.req_done != 2'b00) dones++;
      if (dones == 4) break;
    end
    io.req_valid = 2'b00;
    chk("contention_dones", 32'(dones), 32'd4);
    repeat (8) @(negedge clk);
    gap_en = 1'b0;

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
